// File: rtl/i2c_pkg.sv
// Shared types for the I2C arbiter: arbitration FSM state encoding.
package i2c_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a pointer, pointer
// advances past the granted requester when advance_i is set.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk_i,
    input  logic                 a_rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW:0] NumReq = (IdxW+1)'(N);

    logic [IdxW-1:0] ptr_q, ptr_d;

    // b is always < N, so a single conditional subtract gives the modulo.
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] a,
                                                 input logic [IdxW:0]   b);
        logic [IdxW:0] sum;
        sum = {1'b0, a} + b;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return sum[IdxW-1:0];
    endfunction

    always_comb begin
        logic            found;
        logic [IdxW-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = wrap_add(ptr_q, (IdxW+1)'(i));
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = wrap_add(gnt_idx_o, (IdxW+1)'(1));
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between REQ_NUM requesters: round-robin accept, issue,
// wait for done or timeout, then answer the issuing requester.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 16,
    parameter int unsigned TO_WIDTH    = 24
) (
    input  logic                            clk_i,
    input  logic                            a_rst_i,
    input  logic [PRESC_WIDTH-1:0]          cfg_prescale_i,
    input  logic [TO_WIDTH-1:0]             cfg_timeout_i,
    input  logic [REQ_NUM-1:0]              s_valid_i,
    output logic [REQ_NUM-1:0]              s_ready_o,
    input  logic [REQ_NUM*(DATA_WIDTH-1)-1:0] s_addr_i,
    input  logic [REQ_NUM-1:0]              s_dir_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   s_data_i,
    output logic                            rsp_valid_o,
    output logic [$clog2(REQ_NUM)-1:0]      rsp_id_o,
    output logic [DATA_WIDTH-1:0]           rsp_data_o,
    output logic                            rsp_err_o,
    output logic                            busy_o,
    output logic                            m_en_o,
    output logic [PRESC_WIDTH-1:0]          m_prescale_o,
    output logic [DATA_WIDTH-2:0]           m_slave_addr_o,
    output logic                            m_dir_o,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    input  logic                            m_done_i,
    input  logic [DATA_WIDTH-1:0]           m_rdata_i
);

    localparam int unsigned ADDR_WIDTH = DATA_WIDTH - 1;
    localparam int unsigned IdW        = $clog2(REQ_NUM);

    arb_state_t             state_q, state_d;
    logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PRESC_WIDTH-1:0] prescale_q, prescale_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   dir_q, dir_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [IdW-1:0]         id_q, id_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [REQ_NUM-1:0]     gnt;
    logic [IdW-1:0]         gnt_idx;
    logic                   advance;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_dir;
    logic [DATA_WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .a_rst_i   (a_rst_i),
        .req_i     (s_valid_i),
        .advance_i (advance),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_dir  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (gnt[i]) begin
                sel_addr = s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dir  = s_dir_i[i];
                sel_data = s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prescale_d = prescale_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        data_d     = data_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        advance    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|s_valid_i) begin
                    advance    = 1'b1;
                    prescale_d = cfg_prescale_i;
                    addr_d     = sel_addr;
                    dir_d      = sel_dir;
                    data_d     = sel_data;
                    id_d       = gnt_idx;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Done takes priority over a timeout expiring in the same cycle.
                if (m_done_i) begin
                    rsp_data_d = dir_q ? m_rdata_i : '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (cfg_timeout_i != '0 && cnt_q == cfg_timeout_i - TO_WIDTH'(1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            prescale_q <= '0;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prescale_q <= prescale_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign s_ready_o      = (state_q == StIdle) ? gnt : '0;
    assign busy_o         = (state_q != StIdle);
    assign m_en_o         = (state_q == StIssue) || (state_q == StWait);
    assign rsp_valid_o    = (state_q == StResp);
    assign rsp_id_o       = id_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = rsp_err_q;
    assign m_prescale_o   = prescale_q;
    assign m_slave_addr_o = addr_q;
    assign m_dir_o        = dir_q;
    assign m_data_o       = data_q;

endmodule
